ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding request to instruction memory,
// with a 2-entry in-order buffer in front of decode and flush/redirect handling.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN (misaligned PCs fault and skip memory).
module ifetch_ctrl #(
    parameter int unsigned D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] pc_i,
    input  logic               pc_valid_i,
    output logic               pc_ready_o,
    input  logic               flush_i,
    output logic               imem_req_o,
    output logic [D_WIDTH-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [D_WIDTH-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [D_WIDTH-1:0] instr_o,
    output logic [D_WIDTH-1:0] instr_pc_o,
    output logic               instr_fault_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDrop
    } state_e;

    state_e             state_q, state_d;
    logic [D_WIDTH-1:0] addr_q, addr_d;
    // Remembers a flush seen in REQ before the grant arrived.
    logic               drop_q, drop_d;

    logic [D_WIDTH-1:0] instr_mem_q [2];
    logic [D_WIDTH-1:0] pc_mem_q    [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;

    logic               pc_accept;
    logic               push;
    logic               pop;
    logic [D_WIDTH-1:0] push_instr;
    logic [D_WIDTH-1:0] push_pc;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic               fault_mem_q [2];
    logic               push_fault;
`endif

    assign pop           = (count_q != 2'd0) && instr_ready_i;
    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = instr_mem_q[rd_ptr_q];
    assign instr_pc_o    = pc_mem_q[rd_ptr_q];

`ifdef IFETCH_MISALIGN_CHK_EN
    assign instr_fault_o = fault_mem_q[rd_ptr_q];
    assign imem_addr_o   = addr_q;
`else
    assign instr_fault_o = 1'b0;
    assign imem_addr_o   = {addr_q[D_WIDTH-1:2], 2'b00};
`endif

    // Next-state, handshake and buffer-push decisions.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drop_d     = drop_q;
        push       = 1'b0;
        push_instr = imem_rdata_i;
        push_pc    = addr_q;
        imem_req_o = 1'b0;
        pc_accept  = 1'b0;
        pc_ready_o = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        push_fault = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // A slot must be free now: only this fetch can push before it retires.
                pc_ready_o = !flush_i && (count_q < 2'd2);
                pc_accept  = pc_valid_i && pc_ready_o;
                if (pc_accept) begin
                    addr_d = pc_i;
`ifdef IFETCH_MISALIGN_CHK_EN
                    if (pc_i[1:0] != 2'b00) begin
                        push       = 1'b1;
                        push_instr = '0;
                        push_pc    = pc_i;
                        push_fault = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
`else
                    state_d = StReq;
`endif
                end
            end
            StReq: begin
                imem_req_o = 1'b1;
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (imem_gnt_i) begin
                    drop_d  = 1'b0;
                    state_d = (flush_i || drop_q) ? StDrop : StResp;
                end
            end
            StResp: begin
                if (imem_rvalid_i) begin
                    push    = !flush_i;
                    state_d = StIdle;
                end else if (flush_i) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    // Buffer pointers and occupancy; flush empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Buffer storage; contents are only meaningful where occupancy says so.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push) begin
            instr_mem_q[wr_ptr_q] <= push_instr;
            pc_mem_q[wr_ptr_q]    <= push_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
            fault_mem_q[wr_ptr_q] <= push_fault;
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: stimulus pushes expected decode entries,
// a monitor pops and compares them whenever decode consumes one.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_fault_o;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    ifetch_ctrl #(.D_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .pc_ready_o    (pc_ready_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_fault_o (instr_fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consumed entries are compared against the scoreboard in issue order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr actual pc=%h instr=%h required none",
                         instr_pc_o, instr_o);
            end else begin
                e = exp_q.pop_front();
                chk("mon_instr", instr_o, e.instr);
                chk("mon_pc", instr_pc_o, e.pc);
                chk("mon_fault", {31'd0, instr_fault_o}, {31'd0, e.fault});
            end
        end
    end

    task automatic wait_pc_ready();
        int t = 0;
        while (!pc_ready_o && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL pc_ready_timeout actual=0 required=1");
        end
    endtask

    // Full fetch: handshake, grant after gnt_wait stall cycles, rvalid the cycle after grant.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int gnt_wait);
        logic [31:0] first_addr;
        exp_t        e;
        wait_pc_ready();
        pc_i       = pc;
        pc_valid_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        first_addr = imem_addr_o;
        chk("req_addr", imem_addr_o, pc & 32'hFFFF_FFFC);
        for (int i = 0; i < gnt_wait; i++) begin
            chk("stall_req", {31'd0, imem_req_o}, 32'd1);
            chk("stall_addr", imem_addr_o, first_addr);
            step();
        end
        chk("gnt_req", {31'd0, imem_req_o}, 32'd1);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("resp_no_req", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        e.instr = data;
        e.pc    = pc;
        e.fault = 1'b0;
        exp_q.push_back(e);
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst           = 1'b1;
        pc_i          = 32'h0;
        pc_valid_i    = 1'b0;
        flush_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_fault", {31'd0, instr_fault_o}, 32'd0);
        chk("rst_pc_ready", {31'd0, pc_ready_o}, 32'd1);

        // Basic fetch with same-cycle grant.
        instr_ready_i = 1'b0;
        do_fetch(32'h0000_0004, 32'h0050_0093, 0);
        chk("basic_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("basic_instr", instr_o, 32'h0050_0093);
        chk("basic_pc", instr_pc_o, 32'h0000_0004);
        instr_ready_i = 1'b1;
        step();
        step();

        // Backpressure: two buffered entries, acceptance blocked, head stable.
        instr_ready_i = 1'b0;
        do_fetch(32'h0000_0000, 32'h1111_1111, 0);
        do_fetch(32'h0000_0004, 32'h2222_2222, 0);
        chk("bp_pc_ready", {31'd0, pc_ready_o}, 32'd0);
        chk("bp_head_pc", instr_pc_o, 32'h0000_0000);
        step();
        step();
        step();
        chk("bp_head_hold", instr_pc_o, 32'h0000_0000);
        chk("bp_head_instr", instr_o, 32'h1111_1111);
        chk("bp_idle_req", {31'd0, imem_req_o}, 32'd0);
        instr_ready_i = 1'b1;
        step();
        step();
        step();
        chk("bp_drained", {31'd0, instr_valid_o}, 32'd0);

        // Grant stall of 5 cycles.
        do_fetch(32'h0000_0040, 32'hAABB_CCDD, 5);
        step();
        step();

        // Flush in RESP before rvalid; the returning data must be dropped.
        wait_pc_ready();
        pc_i       = 32'h0000_0080;
        pc_valid_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        flush_i    = 1'b1;
        step();
        flush_i = 1'b0;
        chk("drop_no_req", {31'd0, imem_req_o}, 32'd0);
        chk("drop_pc_ready", {31'd0, pc_ready_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        chk("flresp_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("flresp_idle", {31'd0, pc_ready_o}, 32'd1);
        do_fetch(32'h0000_0100, 32'h1234_5678, 0);
        step();
        step();

        // Flush in REQ without grant: request held, then drop after grant.
        wait_pc_ready();
        pc_i       = 32'h0000_0200;
        pc_valid_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        flush_i    = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flreq_req_held", {31'd0, imem_req_o}, 32'd1);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("flreq_drop_req", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        step();
        imem_rvalid_i = 1'b0;
        chk("flreq_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("flreq_idle", {31'd0, pc_ready_o}, 32'd1);

        // Flush in IDLE empties the buffer and blocks acceptance.
        instr_ready_i = 1'b0;
        do_fetch(32'h0000_0300, 32'h3333_3333, 0);
        chk("flbuf_valid_pre", {31'd0, instr_valid_o}, 32'd1);
        flush_i = 1'b1;
        exp_q.delete();
        #1;
        chk("flbuf_pc_ready", {31'd0, pc_ready_o}, 32'd0);
        step();
        flush_i = 1'b0;
        chk("flbuf_valid", {31'd0, instr_valid_o}, 32'd0);
        instr_ready_i = 1'b1;

        // Reset mid-REQ.
        wait_pc_ready();
        pc_i       = 32'h0000_0400;
        pc_valid_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        chk("rstreq_req", {31'd0, imem_req_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstreq_req_after", {31'd0, imem_req_o}, 32'd0);
        chk("rstreq_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rstreq_pc_ready", {31'd0, pc_ready_o}, 32'd1);

        // Misaligned PC.
`ifdef IFETCH_MISALIGN_CHK_EN
        wait_pc_ready();
        pc_i       = 32'h0000_0006;
        pc_valid_i = 1'b1;
        e.instr    = 32'h0;
        e.pc       = 32'h0000_0006;
        e.fault    = 1'b1;
        exp_q.push_back(e);
        step();
        pc_valid_i = 1'b0;
        chk("mis_no_req", {31'd0, imem_req_o}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("mis_fault", {31'd0, instr_fault_o}, 32'd1);
        chk("mis_pc", instr_pc_o, 32'h0000_0006);
`else
        do_fetch(32'h0000_0006, 32'h0000_6666, 0);
        chk("mis_fault_tied", {31'd0, instr_fault_o}, 32'd0);
`endif
        step();
        step();
        step();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
